exec_wb_stage: RTL and testbench
================================

Name: exec_wb_stage

Overview:
- Execute/write-back stage that sits directly in front of the 32x32 register bank.
- Accepts one instruction per cycle (opcode, two source register numbers, one destination register number, immediate) over a valid/ready handshake.
- Drives the bank's two read addresses, captures the read data with forwarding, and computes the result (single-cycle ALU or 32-cycle iterative multiply).
- Drives the bank's write port (dr, wrdata, write).

Parameters:
DW, 32, data width
AW, 5, register number width
IMMW, 16, immediate width (zero-extended to DW)
MULCYC, 32, multiply iteration count (must equal DW)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clk
in_valid  input  1  instruction present
in_ready  output  1  stage can accept this cycle
in_op  input  4  opcode
in_sr1  input  AW  source register 1
in_sr2  input  AW  source register 2
in_dr  input  AW  destination register
in_imm  input  IMMW  immediate (ADDI only)
sr1  output  AW  bank read address 1 (combinational = in_sr1)
sr2  output  AW  bank read address 2 (combinational = in_sr2)
rdData1  input  DW  bank read data 1 (combinational read)
rdData2  input  DW  bank read data 2
dr  output  AW  bank write address (registered)
wrdata  output  DW  bank write data (registered)
write  output  1  bank write enable (registered)
busy  output  1  S1 or S2 valid, or multiply in progress

Behaviour:
- Reset (reset==0 at an edge):
  - Clears s1_valid, s2_valid, mul counter and state (to IDLE).
  - write=0, dr=0, wrdata=0, busy=0.
  - Reset mid-multiply aborts it; no write is produced.
- Accept rule: accept = in_valid && in_ready. in_ready = !(state==MUL).
- S1 register:
  - Loads at an accept edge with op, dr, imm and operands a/b.
  - Otherwise it goes invalid at the edge when its contents move to S2.
- Operand forwarding, per source, newest first:
  1. s1_valid, non-MUL, s1_dr==src -> current ALU result.
  2. else write && dr==src -> wrdata.
  3. else rdDataN.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL by b[4:0], 6 SRL by b[4:0] (logical).
  - 7 SLT: signed compare, result 1/0.
  - 8 ADDI: a + zext(imm); sr2 is ignored.
  - 9 MUL: low DW bits of a*b, unsigned.
  - 10-15 are NOPs: they flow through but never assert write.
- All arithmetic is modulo 2^DW; carries are dropped.
- Single-cycle op accepted at edge E0:
  - S2 loads at E1: write=1, dr, wrdata valid during E1..E2.
  - The bank updates at E2.
- MUL:
  - S1 loading a MUL moves state IDLE->MUL at E0; in_ready=0 from E0.
  - Shift-add over MULCYC edges (E1..E32).
  - The product loads S2 at E33 (write=1 for E33..E34) and state returns to IDLE. in_ready=1 after E33.
  - While in MUL, S2 loads bubbles (write=0 after the prior write retires).
- write is high for exactly one cycle per non-NOP instruction.
- Back-to-back accepts sustain one write per cycle.
- Register 0 is an ordinary register; no special casing.
- A simultaneous forward hit on both sources is handled independently per source.

Decomposition:
- Package exec_pkg: opcode localparams (OP_ADD..OP_MUL), DW/AW/IMMW defaults, state encoding (IDLE, MUL).
- Sub-module iter_mul: start, a, b -> done pulse, product; 32-cycle shift-add.
- ALU stays inline as a combinational case statement.

Test Plan:
- Reset, then ADDI r1=r0+10 and ADDI r2=r0+20 on consecutive cycles -> write pulses at E1 and E2 with (1,10), (2,20).
- ADDI r3=r0+5 immediately followed by ADD r4=r3+r3 -> S1 forwarding; write (4,10) one cycle after (3,5).
- ADD r5=r1+r2 one cycle after r2 is written -> S2 forwarding gives (5,30); SUB r6=r1-r2 gives (6,0xFFFFFFF6).
- SLT r7=r6<r1 -> 1. SRL r8=r6>>r... with shift 4 -> 0x0FFFFFFF. SLL by 0 -> unchanged.
- MUL r9=r1*r2 -> in_ready low for 33 cycles, single write (9,200) at E33, in_valid held high meanwhile and not accepted until after.
- Assert reset at E10 of a MUL -> no write ever for r9, in_ready=1 and busy=0 after the reset edge. Opcode 12 -> no write.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcodes, default widths and stage state encoding for the execute/write-back stage.
// Pure declarations: no timing, no handshake.
package exec_pkg;

  localparam int DW_DEFAULT     = 32;
  localparam int AW_DEFAULT     = 5;
  localparam int IMMW_DEFAULT   = 16;
  localparam int MULCYC_DEFAULT = 32;
  localparam int OPW            = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_AND  = 4'd2;
  localparam logic [OPW-1:0] OP_OR   = 4'd3;
  localparam logic [OPW-1:0] OP_XOR  = 4'd4;
  localparam logic [OPW-1:0] OP_SLL  = 4'd5;
  localparam logic [OPW-1:0] OP_SRL  = 4'd6;
  localparam logic [OPW-1:0] OP_SLT  = 4'd7;
  localparam logic [OPW-1:0] OP_ADDI = 4'd8;
  localparam logic [OPW-1:0] OP_MUL  = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Opcodes above OP_MUL are NOPs: they occupy the pipe but never write.
  function automatic logic op_writes(input logic [OPW-1:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/exec_wb_stage_iter_mul.sv
// Shift-add multiplier: operands latched on start, MULCYC iterations, then done_o for one cycle.
// No backpressure: product_o is valid while done_o is high and the caller must take it then.
module iter_mul
  import exec_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int MULCYC = MULCYC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          done_o,
  output logic [DW-1:0] product_o
);

  localparam int CW = $clog2(MULCYC + 1);

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          last;

  assign last      = (cnt_q == CW'(MULCYC));
  assign done_o    = run_q && last;
  assign product_o = acc_q;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (last) begin
        run_d = 1'b0;
      end else begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage in front of the register bank: S1 operand capture with forwarding, S2 write port.
// ALU ops write one cycle after accept; MUL writes 33 cycles after accept with in_ready low until then.
module exec_wb_stage
  import exec_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int AW     = AW_DEFAULT,
  parameter int IMMW   = IMMW_DEFAULT,
  parameter int MULCYC = MULCYC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [AW-1:0]   in_sr1,
  input  logic [AW-1:0]   in_sr2,
  input  logic [AW-1:0]   in_dr,
  input  logic [IMMW-1:0] in_imm,
  output logic [AW-1:0]   sr1,
  output logic [AW-1:0]   sr2,
  input  logic [DW-1:0]   rdData1,
  input  logic [DW-1:0]   rdData2,
  output logic [AW-1:0]   dr,
  output logic [DW-1:0]   wrdata,
  output logic            write,
  output logic            busy
);

  localparam int SHW = $clog2(DW);

  state_e          state_q, state_d;
  logic            s1_valid_q, s1_valid_d;
  logic [OPW-1:0]  s1_op_q, s1_op_d;
  logic [AW-1:0]   s1_dr_q, s1_dr_d;
  logic [IMMW-1:0] s1_imm_q, s1_imm_d;
  logic [DW-1:0]   s1_a_q, s1_a_d;
  logic [DW-1:0]   s1_b_q, s1_b_d;
  logic            s2_valid_q, s2_valid_d;
  logic            write_q, write_d;
  logic [AW-1:0]   dr_q, dr_d;
  logic [DW-1:0]   wrdata_q, wrdata_d;

  logic            accept;
  logic            mul_start;
  logic            mul_done;
  logic [DW-1:0]   mul_prod;
  logic            s1_move;
  logic            s1_fwd_ok;
  logic [DW-1:0]   fwd_a, fwd_b;
  logic [DW-1:0]   alu_res;

  assign in_ready  = (state_q != ST_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (in_op == OP_MUL);
  assign s1_move   = s1_valid_q && ((s1_op_q != OP_MUL) || mul_done);

  // A MUL in S1 has no result yet and a NOP never reaches the bank, so neither may forward.
  assign s1_fwd_ok = s1_valid_q && op_writes(s1_op_q) && (s1_op_q != OP_MUL);

  assign fwd_a = (s1_fwd_ok && (s1_dr_q == in_sr1)) ? alu_res  :
                 (write_q   && (dr_q    == in_sr1)) ? wrdata_q : rdData1;
  assign fwd_b = (s1_fwd_ok && (s1_dr_q == in_sr2)) ? alu_res  :
                 (write_q   && (dr_q    == in_sr2)) ? wrdata_q : rdData2;

  assign sr1    = in_sr1;
  assign sr2    = in_sr2;
  assign dr     = dr_q;
  assign wrdata = wrdata_q;
  assign write  = write_q;
  assign busy   = s1_valid_q || s2_valid_q || (state_q == ST_MUL);

  always_comb begin
    alu_res = '0;
    case (s1_op_q)
      OP_ADD:  alu_res = s1_a_q + s1_b_q;
      OP_SUB:  alu_res = s1_a_q - s1_b_q;
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
      OP_SLL:  alu_res = s1_a_q << s1_b_q[SHW-1:0];
      OP_SRL:  alu_res = s1_a_q >> s1_b_q[SHW-1:0];
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OP_ADDI: alu_res = s1_a_q + {{(DW-IMMW){1'b0}}, s1_imm_q};
      default: alu_res = '0;
    endcase
  end

  iter_mul #(
    .DW     (DW),
    .MULCYC (MULCYC)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (fwd_a),
    .b_i       (fwd_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_dr_d    = s1_dr_q;
    s1_imm_d   = s1_imm_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_dr_d    = in_dr;
      s1_imm_d   = in_imm;
      s1_a_d     = fwd_a;
      s1_b_d     = fwd_b;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 takes a bubble on every cycle S1 has nothing to hand over.
  always_comb begin
    s2_valid_d = s1_move;
    write_d    = s1_move && op_writes(s1_op_q);
    dr_d       = dr_q;
    wrdata_d   = wrdata_q;
    if (s1_move) begin
      dr_d     = s1_dr_q;
      wrdata_d = (s1_op_q == OP_MUL) ? mul_prod : alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_dr_q    <= '0;
      s1_imm_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      write_q    <= 1'b0;
      dr_q       <= '0;
      wrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_dr_q    <= s1_dr_d;
      s1_imm_q   <= s1_imm_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      write_q    <= write_d;
      dr_q       <= dr_d;
      wrdata_q   <= wrdata_d;
    end
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: bank model, directed vector table, MUL/abort sequences, random program vs architectural model.
module tb_exec_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_sr1, in_sr2, in_dr;
  logic [15:0] in_imm;
  logic [4:0]  sr1, sr2, dr;
  logic [31:0] rdData1, rdData2, wrdata;
  logic        write, busy;

  exec_wb_stage dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_sr1   (in_sr1),
    .in_sr2   (in_sr2),
    .in_dr    (in_dr),
    .in_imm   (in_imm),
    .sr1      (sr1),
    .sr2      (sr2),
    .rdData1  (rdData1),
    .rdData2  (rdData2),
    .dr       (dr),
    .wrdata   (wrdata),
    .write    (write),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank the stage drives: combinational read, write at the clock edge.
  logic [31:0] bank [32];
  logic        bank_clr;
  always @(posedge clk) begin
    if (bank_clr) begin
      for (int r = 0; r < 32; r++) bank[r] <= '0;
    end else if (write) begin
      bank[dr] <= wrdata;
    end
  end
  assign rdData1 = bank[sr1];
  assign rdData2 = bank[sr2];

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
    int          c;
  } wr_t;

  wr_t wlog[$];
  wr_t exp_q[$];
  always @(negedge clk) if (write === 1'b1) wlog.push_back('{dr, wrdata, cyc});

  logic [31:0] model_rf [32];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [15:0] imm);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: return a + {16'h0, imm};
      4'd9: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Present one instruction, hold it until accepted; the model retires it in program order.
  task automatic send(input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic [15:0] imm, input bit commit,
                      output int waited);
    logic [31:0] val;
    waited   = 0;
    in_op    = op;
    in_sr1   = s1;
    in_sr2   = s2;
    in_dr    = d;
    in_imm   = imm;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    val = ref_op(op, model_rf[s1], model_rf[s2], imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (commit && op <= 4'd9) begin
      exp_q.push_back('{d, val, cyc + ((op == 4'd9) ? 33 : 1)});
      model_rf[d] = val;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(busy), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic drain_check(input string nm);
    wr_t g, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wlog.size() == 0) begin
        chk({nm, "_missing"}, 64'd0, {11'd0, e.d, e.v, e.c[15:0]});
      end else begin
        g = wlog.pop_front();
        chk(nm, {11'd0, g.d, g.v, g.c[15:0]}, {11'd0, e.d, e.v, e.c[15:0]});
      end
    end
    chk({nm, "_extra"}, 64'(wlog.size()), 64'd0);
    wlog.delete();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  s1, s2, d;
    logic [15:0] imm;
    bit          wr;
    logic [31:0] val;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int w, k;
    tbl[0]  = '{4'd8,  5'd0, 5'd0,  5'd1,  16'd10,     1'b1, 32'd10};
    tbl[1]  = '{4'd8,  5'd0, 5'd0,  5'd2,  16'd20,     1'b1, 32'd20};
    tbl[2]  = '{4'd0,  5'd1, 5'd2,  5'd5,  16'd0,      1'b1, 32'd30};
    tbl[3]  = '{4'd8,  5'd0, 5'd0,  5'd3,  16'd5,      1'b1, 32'd5};
    tbl[4]  = '{4'd0,  5'd3, 5'd3,  5'd4,  16'd0,      1'b1, 32'd10};
    tbl[5]  = '{4'd1,  5'd1, 5'd2,  5'd6,  16'd0,      1'b1, 32'hFFFFFFF6};
    tbl[6]  = '{4'd7,  5'd6, 5'd1,  5'd7,  16'd0,      1'b1, 32'd1};
    tbl[7]  = '{4'd8,  5'd0, 5'd0,  5'd10, 16'd4,      1'b1, 32'd4};
    tbl[8]  = '{4'd6,  5'd6, 5'd10, 5'd8,  16'd0,      1'b1, 32'h0FFFFFFF};
    tbl[9]  = '{4'd5,  5'd6, 5'd0,  5'd11, 16'd0,      1'b1, 32'hFFFFFFF6};
    tbl[10] = '{4'd2,  5'd6, 5'd1,  5'd12, 16'd0,      1'b1, 32'h00000002};
    tbl[11] = '{4'd3,  5'd1, 5'd2,  5'd13, 16'd0,      1'b1, 32'h0000001E};
    tbl[12] = '{4'd4,  5'd6, 5'd2,  5'd14, 16'd0,      1'b1, 32'hFFFFFFE2};
    tbl[13] = '{4'd12, 5'd6, 5'd1,  5'd15, 16'd0,      1'b0, 32'd0};
    tbl[14] = '{4'd8,  5'd0, 5'd0,  5'd15, 16'hFFFF,   1'b1, 32'h0000FFFF};
    tbl[15] = '{4'd0,  5'd6, 5'd15, 5'd16, 16'd0,      1'b1, 32'h0000FFF5};

    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    reset    = 1'b0;
    bank_clr = 1'b1;
    in_valid = 1'b0;
    in_op    = '0;
    in_sr1   = '0;
    in_sr2   = '0;
    in_dr    = '0;
    in_imm   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write",  64'(write),    64'd0);
    chk("rst_dr",     64'(dr),       64'd0);
    chk("rst_wrdata", 64'(wrdata),   64'd0);
    chk("rst_busy",   64'(busy),     64'd0);
    chk("rst_ready",  64'(in_ready), 64'd1);
    reset    = 1'b1;
    bank_clr = 1'b0;
    @(posedge clk); #1;

    // Back-to-back directed program exercising both forwarding paths and every ALU op.
    for (int i = 0; i < 16; i++) send(tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].imm, 1'b1, w);
    drain();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        if (k < wlog.size())
          chk($sformatf("vec%0d", i), {27'd0, wlog[k].d, wlog[k].v}, {27'd0, tbl[i].d, tbl[i].val});
        else
          chk($sformatf("vec%0d_missing", i), 64'd0, 64'd1);
        k++;
      end
    end
    chk("vec_count", 64'(wlog.size()), 64'(k));
    drain_check("dir");

    // MUL with the next instruction held valid behind it.
    send(4'd9, 5'd1, 5'd2, 5'd9, 16'd0, 1'b1, w);
    chk("mul_busy", 64'(busy), 64'd1);
    send(4'd8, 5'd0, 5'd0, 5'd20, 16'd7, 1'b1, w);
    chk("mul_ready_low", 64'(w), 64'd33);
    drain();
    if (wlog.size() > 0) chk("mul_result", {27'd0, wlog[0].d, wlog[0].v}, {27'd0, 5'd9, 32'd200});
    else chk("mul_result_missing", 64'd0, 64'd1);
    drain_check("mul");

    // Reset lands on the tenth edge of a multiply: it must vanish without a write.
    send(4'd9, 5'd1, 5'd2, 5'd21, 16'd0, 1'b0, w);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_busy",  64'(busy),     64'd0);
    chk("abort_write", 64'(write),    64'd0);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_nowrite", 64'(wlog.size()), 64'd0);
    wlog.delete();

    // Random program over a small register window to keep forwarding hits frequent.
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [4:0]  s1, s2, d;
      logic [15:0] imm;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      op  = 4'($urandom_range(0, 15));
      s1  = 5'($urandom_range(0, 7));
      s2  = 5'($urandom_range(0, 7));
      d   = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      send(op, s1, s2, d, imm, 1'b1, w);
    end
    drain();
    drain_check("rand");

    for (int r = 0; r < 32; r++) chk($sformatf("rf%0d", r), 64'(bank[r]), 64'(model_rf[r]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
